operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Operand fetch stage sitting directly upstream of the register file in micro_mips.
- Accepts one instruction word at a time over a valid/ready handshake.
- Decodes the register fields and issues the read to the register file.
- Captures rd1/rd2 and presents a decoded operand bundle to the execute stage.
- Arbitrates the register file's single port between reads (we=0) and writeback writes (we=1), which cannot occur in the same cycle.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a pending read may be deferred by writebacks before the read wins arbitration (1..15)

Ports:
clk  in  1  clock, all state on rising edge
res  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction word valid
instr  in  32  MIPS instruction word
instr_ready  out  1  stage can accept an instruction
wb_valid  in  1  writeback request
wb_addr  in  5  writeback destination register
wb_data  in  32  writeback data
wb_ready  out  1  writeback accepted this cycle
rf_a1  out  5  register file read address 1 (rs)
rf_a2  out  5  register file read address 2 (rt)
rf_a3  out  5  register file write address
rf_wd3  out  32  register file write data
rf_we  out  1  register file write enable; 0 = read cycle
rf_rd1  in  32  register file read data 1 (registered inside the register file)
rf_rd2  in  32  register file read data 2
op_valid  out  1  operand bundle valid
op_ready  in  1  execute stage accepts bundle
op_a  out  32  rs value
op_b  out  32  rt value
op_imm  out  32  extended immediate
op_dst  out  5  destination register
op_opcode  out  6  instr[31:26]
op_funct  out  6  instr[5:0]

Behaviour:
- Reset:
  - state=IDLE; starve counter=0.
  - All registered outputs are 0: op_*, rf_a1/a2/a3, rf_wd3.
  - instr_ready=0 while res is high.
- States:
  - IDLE: instr_ready=1. instr_valid&&instr_ready latches instr and rs/rt into rf_a1/rf_a2, then goes to READ.
  - READ:
    - No wb_valid: cycle is a read (rf_we=0), go to CAPTURE.
    - wb_valid and counter<STARVE_LIMIT: write wins, counter++, stay in READ.
    - wb_valid and counter==STARVE_LIMIT: read wins, wb_ready=0, counter cleared, go to CAPTURE.
  - CAPTURE: rf_rd1/rf_rd2 hold the read data. Load op_a/op_b (forced to 0 when the address is 0). Load op_imm and op_dst. Go to VALID.
  - VALID: op_valid=1. op_valid&&op_ready goes to IDLE. Bundle stays stable while op_ready=0.
- rf_a1/rf_a2 stay stable from IDLE accept until CAPTURE completes.
- Minimum latency: accept at cycle 0, READ at cycle 1, CAPTURE at cycle 2, op_valid=1 at cycle 3. Back-to-back instructions are accepted every 4 cycles minimum.
- Writeback:
  - wb_ready=1 in every state, except the starvation-win cycle in READ.
  - An accepted write drives rf_we=1, rf_a3=wb_addr, rf_wd3=wb_data combinationally in the same cycle.
  - wb_addr==0 is accepted, but rf_we stays 0 ($0 is never written).
- Immediate:
  - Opcodes 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend instr[15:0].
  - All other opcodes: sign-extend instr[15:0].
- op_dst = instr[15:11] when opcode==0, else instr[20:16].
- Reset mid-operation (any state): return to IDLE immediately. Any in-flight instruction is dropped. op_valid=0.

Optional Feature:
OPF_WB_BYPASS_EN
- Defined:
  - A write accepted in the CAPTURE cycle whose wb_addr (≠0) matches rs/rt loads wb_data into op_a/op_b instead of rf_rd1/rf_rd2.
  - A write accepted in the VALID state updates the matching op_a/op_b on the next edge.
- Undefined: operands reflect the register file contents at the READ cycle only. Software inserts the hazard spacing.

Test Plan:
1. Reset, then regfile preloaded r9=5 and r10=7; send 0x012A5820 (add r11,r9,r10) with op_ready=1. Expect op_valid at cycle 3, op_a=5, op_b=7, op_dst=11, op_funct=0x20.
2. Send ori r8,r0,0xFFFF; expect op_imm=0x0000FFFF and op_a=0. Send addi with 0xFFFF; expect op_imm=0xFFFFFFFF.
3. Hold wb_valid=1 continuously during READ, STARVE_LIMIT=4. Expect 4 writes with rf_we=1, then one cycle with wb_ready=0 and rf_we=0, then CAPTURE.
4. wb_addr=0 with wb_valid=1, wb_data=0xDEADBEEF. Expect wb_ready=1 and rf_we=0.
5. With OPF_WB_BYPASS_EN, in VALID with op_ready=0, write r9=0x1234 where rs=9. Expect op_a=0x1234 next cycle. Without the macro, expect op_a unchanged.
6. Assert res while in VALID. Expect op_valid=0 and instr_ready=0 immediately, then instr_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: operand fetch stage in front of the micro_mips register file.
// Accepts one instruction at a time, reads rs/rt through the single register
// file port (shared with writebacks), and presents a decoded operand bundle.
// Optional feature macro: OPF_WB_BYPASS_EN -- when defined, writebacks that
// land during CAPTURE or VALID are forwarded into the matching op_a/op_b.
module operand_fetch #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic        rf_we,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_imm,
    output logic [4:0]  op_dst,
    output logic [5:0]  op_opcode,
    output logic [5:0]  op_funct
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_VALID   = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic logic [31:0] ext_imm(input logic [5:0] opcode, input logic [15:0] imm16);
        logic [31:0] v;
        case (opcode)
            OPC_ANDI, OPC_ORI, OPC_XORI: v = {16'h0000, imm16};
            default:                     v = {{16{imm16[15]}}, imm16};
        endcase
        return v;
    endfunction

    // R-type writes rd, every other format writes rt.
    function automatic logic [4:0] sel_dst(input logic [5:0] opcode, input logic [15:0] lo16,
                                           input logic [4:0] rt);
        logic [4:0] d;
        if (opcode == OPC_RTYPE) begin
            d = lo16[15:11];
        end else begin
            d = rt;
        end
        return d;
    endfunction

    logic [1:0]  r_state;
    logic [3:0]  r_starve;
    logic [5:0]  r_opcode;
    logic [15:0] r_lo16;
    logic [4:0]  r_rf_a1;
    logic [4:0]  r_rf_a2;
    logic        r_op_valid;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_op_imm;
    logic [4:0]  r_op_dst;
    logic [5:0]  r_op_opcode;
    logic [5:0]  r_op_funct;

    logic [1:0]  w_next_state;
    logic [3:0]  w_starve_next;
    logic        w_read_wins;
    logic        w_instr_ready;
    logic        w_instr_fire;
    logic        w_wb_ready;
    logic        w_wb_fire;
    logic        w_wb_write;
    logic [31:0] w_cap_a;
    logic [31:0] w_cap_b;
    logic        w_hit_a;
    logic        w_hit_b;

    // Handshake qualifiers; nothing is accepted while reset is asserted.
    assign w_instr_ready = (r_state == S_IDLE) && !res;
    assign w_instr_fire  = instr_valid && w_instr_ready;
    assign w_wb_ready    = !res && !w_read_wins;
    assign w_wb_fire     = wb_valid && w_wb_ready;
    assign w_wb_write    = w_wb_fire && (wb_addr != 5'd0);

    // Next-state and starvation arbitration between the pending read and writebacks.
    always_comb begin
        w_next_state  = r_state;
        w_starve_next = r_starve;
        w_read_wins   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_instr_fire) begin
                    w_next_state = S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ: begin
                if (!wb_valid) begin
                    w_next_state  = S_CAPTURE;
                    w_starve_next = 4'd0;
                end else if (r_starve >= STARVE_MAX) begin
                    w_read_wins   = 1'b1;
                    w_starve_next = 4'd0;
                    w_next_state  = S_CAPTURE;
                end else begin
                    w_starve_next = r_starve + 4'd1;
                    w_next_state  = S_READ;
                end
            end
            S_CAPTURE: begin
                w_next_state = S_VALID;
            end
            S_VALID: begin
                if (op_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_VALID;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_starve_next = 4'd0;
            end
        endcase
    end

    // Operand selection: $0 reads as zero, optional forwarding of a same-cycle writeback.
    always_comb begin
        w_cap_a = (r_rf_a1 == 5'd0) ? 32'd0 : rf_rd1;
        w_cap_b = (r_rf_a2 == 5'd0) ? 32'd0 : rf_rd2;
`ifdef OPF_WB_BYPASS_EN
        w_hit_a = w_wb_write && (wb_addr == r_rf_a1);
        w_hit_b = w_wb_write && (wb_addr == r_rf_a2);
`else
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
`endif
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_starve <= w_starve_next;
        end
    end

    // Instruction latch, read addresses and the operand bundle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_opcode    <= 6'd0;
            r_lo16      <= 16'd0;
            r_rf_a1     <= 5'd0;
            r_rf_a2     <= 5'd0;
            r_op_valid  <= 1'b0;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_op_imm    <= 32'd0;
            r_op_dst    <= 5'd0;
            r_op_opcode <= 6'd0;
            r_op_funct  <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_instr_fire) begin
                        r_opcode <= instr[31:26];
                        r_lo16   <= instr[15:0];
                        r_rf_a1  <= instr[25:21];
                        r_rf_a2  <= instr[20:16];
                    end
                end
                S_CAPTURE: begin
                    r_op_a      <= w_hit_a ? wb_data : w_cap_a;
                    r_op_b      <= w_hit_b ? wb_data : w_cap_b;
                    r_op_imm    <= ext_imm(r_opcode, r_lo16);
                    r_op_dst    <= sel_dst(r_opcode, r_lo16, r_rf_a2);
                    r_op_opcode <= r_opcode;
                    r_op_funct  <= r_lo16[5:0];
                    r_op_valid  <= 1'b1;
                end
                S_VALID: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                    end
                    if (w_hit_a) begin
                        r_op_a <= wb_data;
                    end
                    if (w_hit_b) begin
                        r_op_b <= wb_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign instr_ready = w_instr_ready;
    assign wb_ready    = w_wb_ready;
    assign rf_we       = w_wb_write;
    assign rf_a3       = w_wb_write ? wb_addr : 5'd0;
    assign rf_wd3      = w_wb_write ? wb_data : 32'd0;
    assign rf_a1       = r_rf_a1;
    assign rf_a2       = r_rf_a2;
    assign op_valid    = r_op_valid;
    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign op_imm      = r_op_imm;
    assign op_dst      = r_op_dst;
    assign op_opcode   = r_op_opcode;
    assign op_funct    = r_op_funct;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: register file stub, scoreboard fed at issue
// time from a register-array reference model, and an independent monitor.
module tb_operand_fetch;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        wb_ready;
    logic [4:0]  rf_a1, rf_a2, rf_a3;
    logic [31:0] rf_wd3;
    logic        rf_we;
    logic [31:0] rf_rd1 = 32'd0;
    logic [31:0] rf_rd2 = 32'd0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_a, op_b, op_imm;
    logic [4:0]  op_dst;
    logic [5:0]  op_opcode, op_funct;

    operand_fetch #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .res(res),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we(rf_we),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_imm(op_imm), .op_dst(op_dst),
        .op_opcode(op_opcode), .op_funct(op_funct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [5:0]  opc;
        logic [5:0]  fn;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_regs [32];
    logic [31:0] mem [32];
    int          n_checks = 0;
    int          n_err = 0;
    bit          rand_done = 1'b0;

    // Register file stub: writes when rf_we, otherwise a registered read.
    // Entry 0 deliberately holds junk so the stage's $0 zeroing is exercised.
    always @(posedge clk) begin
        if (rf_we) mem[rf_a3] <= rf_wd3;
        else begin
            rf_rd1 <= mem[rf_a1];
            rf_rd2 <= mem[rf_a2];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: decode straight from the MIPS field layout and the register array.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int opc = int'(ins >> 26);
        int rs  = int'((ins >> 21) & 32'd31);
        int rt  = int'((ins >> 16) & 32'd31);
        int rd  = int'((ins >> 11) & 32'd31);
        int i16 = int'(ins & 32'hFFFF);
        e.a   = (rs == 0) ? 32'd0 : ref_regs[rs];
        e.b   = (rt == 0) ? 32'd0 : ref_regs[rt];
        if (opc == 12 || opc == 13 || opc == 14 || i16 < 32768) e.imm = 32'(i16);
        else e.imm = 32'(i16) + 32'hFFFF0000;
        e.dst = (opc == 0) ? 5'(rd) : 5'(rt);
        e.opc = 6'(opc);
        e.fn  = 6'(ins & 32'h3F);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (instr_ready) break;
        end
        chk("wait_idle", 32'(instr_ready), 32'd1);
    endtask

    // Call at posedge+1 of an IDLE cycle; returns at posedge+1 of the READ cycle.
    task automatic issue(input logic [31:0] ins, input exp_t e);
        instr_valid = 1'b1;
        instr = ins;
        @(negedge clk);
        chk("instr_ready_accept", 32'(instr_ready), 32'd1);
        sb.push_back(e);
        step();
        instr_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(negedge clk);
        chk("wb_ready", 32'(wb_ready), 32'd1);
        chk("wb_rf_we", 32'(rf_we), 32'(a != 5'd0));
        if (a != 5'd0) begin
            chk("wb_rf_a3", 32'(rf_a3), 32'(a));
            chk("wb_rf_wd3", rf_wd3, d);
            ref_regs[a] = d;
        end
        step();
        wb_valid = 1'b0;
    endtask

    // Monitor: compares every handed-off bundle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!res && op_valid && op_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_unexpected: bundle op_a=0x%h with no expectation", op_a);
                end else begin
                    e = sb.pop_front();
                    chk("op_a", op_a, e.a);
                    chk("op_b", op_b, e.b);
                    chk("op_imm", op_imm, e.imm);
                    chk("op_dst", 32'(op_dst), 32'(e.dst));
                    chk("op_opcode", 32'(op_opcode), 32'(e.opc));
                    chk("op_funct", 32'(op_funct), 32'(e.fn));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] ins;
        logic [31:0] old_a;
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = (i == 0) ? 32'd0 : $urandom;
            mem[i] = ref_regs[i];
        end
        mem[0] = 32'hBAD0_0000;

        // Reset state
        @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_imm", op_imm, 32'd0);
        chk("rst_rf_a1", 32'(rf_a1), 32'd0);
        chk("rst_rf_a2", 32'(rf_a2), 32'd0);
        chk("rst_rf_wd3", rf_wd3, 32'd0);
        step();
        res = 1'b0;
        op_ready = 1'b1;

        // 1: preload r9/r10, add r11,r9,r10 with minimum latency
        wait_idle(); step();
        wb_write(5'd9, 32'd5);
        wb_write(5'd10, 32'd7);
        ins = 32'h012A5820;
        issue(ins, model(ins));
        @(negedge clk);
        chk("c1_op_valid", 32'(op_valid), 32'd0);
        chk("c1_rf_a1", 32'(rf_a1), 32'd9);
        chk("c1_rf_a2", 32'(rf_a2), 32'd10);
        chk("c1_rf_we", 32'(rf_we), 32'd0);
        step(); @(negedge clk);
        chk("c2_op_valid", 32'(op_valid), 32'd0);
        chk("c2_rf_a1", 32'(rf_a1), 32'd9);
        step(); @(negedge clk);
        chk("c3_op_valid", 32'(op_valid), 32'd1);

        // 2: ori r8,r0,0xFFFF then addi r8,r0,0xFFFF
        wait_idle(); step();
        issue(32'h3408FFFF, model(32'h3408FFFF));
        wait_idle(); step();
        issue(32'h2008FFFF, model(32'h2008FFFF));

        // 3: writebacks held through READ; read wins after SL deferrals
        wait_idle(); step();
        ref_regs[12] = 32'h55;
        ins = 32'h01896820;
        issue(ins, model(ins));
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h55;
        for (int i = 0; i < SL; i++) begin
            @(negedge clk);
            chk("starve_wb_ready", 32'(wb_ready), 32'd1);
            chk("starve_rf_we", 32'(rf_we), 32'd1);
            step();
        end
        @(negedge clk);
        chk("starve_win_wb_ready", 32'(wb_ready), 32'd0);
        chk("starve_win_rf_we", 32'(rf_we), 32'd0);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("starve_capture_op_valid", 32'(op_valid), 32'd0);
        step(); @(negedge clk);
        chk("starve_valid_op_valid", 32'(op_valid), 32'd1);

        // 4: write to $0 is accepted but never reaches the register file
        wait_idle(); step();
        wb_write(5'd0, 32'hDEADBEEF);

        // 5a: writeback during VALID with op_ready low
        wait_idle(); step();
        op_ready = 1'b0;
        ins = 32'h012A5820;
        e = model(ins);
        old_a = e.a;
`ifdef OPF_WB_BYPASS_EN
        e.a = 32'h1234;
`endif
        issue(ins, e);
        step(); step();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
        @(negedge clk);
        chk("vbyp_op_valid", 32'(op_valid), 32'd1);
        chk("vbyp_op_a_before", op_a, old_a);
        step();
        wb_valid = 1'b0;
        ref_regs[9] = 32'h1234;
        op_ready = 1'b1;
        @(negedge clk);
        chk("vbyp_op_a_after", op_a, e.a);

        // 5b: writeback landing in the CAPTURE cycle
        wait_idle(); step();
        e = model(ins);
`ifdef OPF_WB_BYPASS_EN
        e.b = 32'h99;
`endif
        issue(ins, e);
        step();
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h99;
        @(negedge clk);
        chk("cbyp_rf_we", 32'(rf_we), 32'd1);
        step();
        wb_valid = 1'b0;
        ref_regs[10] = 32'h99;

        // 6: reset while VALID drops the bundle
        wait_idle(); step();
        op_ready = 1'b0;
        issue(32'h012A5820, model(32'h012A5820));
        step(); step();
        @(negedge clk);
        chk("rst6_pre_op_valid", 32'(op_valid), 32'd1);
        step();
        res = 1'b1;
        #1;
        chk("rst6_op_valid", 32'(op_valid), 32'd0);
        chk("rst6_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst6_op_a", op_a, 32'd0);
        sb.delete();
        step();
        res = 1'b0;
        @(negedge clk);
        chk("rst6_release_instr_ready", 32'(instr_ready), 32'd1);

        // Randomized traffic with a randomly stalling consumer
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [5:0] opc;
                    wait_idle(); step();
                    for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                        wb_write(5'($urandom_range(0, 31)), $urandom);
                    case ($urandom_range(0, 5))
                        0: opc = 6'h00;
                        1: opc = 6'h0C;
                        2: opc = 6'h0D;
                        3: opc = 6'h0E;
                        4: opc = 6'h08;
                        default: opc = 6'($urandom_range(0, 63));
                    endcase
                    ins = {opc, 26'($urandom)};
                    issue(ins, model(ins));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step();
                    op_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        op_ready = 1'b1;
        wait_idle();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
